// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode map, instruction classes and the
// queue entry format used by the fetch front end.
package pipe_pkg;

    localparam int PIPE_AW = 10;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011;
    localparam logic [5:0] OP_XOR  = 6'b000100;
    localparam logic [5:0] OP_SLT  = 6'b000101;
    localparam logic [5:0] OP_HLT  = 6'b000110;
    localparam logic [5:0] OP_LW   = 6'b001000;
    localparam logic [5:0] OP_SW   = 6'b001001;
    localparam logic [5:0] OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_BEQZ = 6'b001011;

    typedef enum logic [1:0] {
        IT_ALU    = 2'd0,
        IT_MEM    = 2'd1,
        IT_BRANCH = 2'd2,
        IT_HALT   = 2'd3
    } instr_type_e;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } iq_entry_t;

    function automatic instr_type_e op_type(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return IT_MEM;
            OP_BEQZ:      return IT_BRANCH;
            OP_HLT:       return IT_HALT;
            default:      return IT_ALU;
        endcase
    endfunction

    function automatic logic is_hlt(input logic [31:0] ir);
        return ir[31:26] == OP_HLT;
    endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Fetch front-end bundle: instruction memory port, redirect input and the
// decode-side handshake. master = fetch unit, slave = memory/decode side.
interface if_prefetch_queue_if #(
    parameter int AW = pipe_pkg::PIPE_AW
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          id_valid;
    logic [31:0]   id_ir;
    logic [31:0]   id_npc;
    logic          id_ready;
    logic          fetch_stopped;

    modport master (
        output imem_req, imem_addr, id_valid, id_ir, id_npc, fetch_stopped,
        input  imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_ir, id_npc, fetch_stopped,
        output imem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/iq_fifo.sv
// Power-of-two synchronous FIFO with flush; flush overrides push and pop.
module iq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic [W-1:0]           dout
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & (count != '0) & ~flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: credit-limited requests into a small queue,
// redirect flush, and fetch stop once an HLT word is captured.
module if_prefetch_queue
    import pipe_pkg::*;
#(
    parameter int            DEPTH    = 4,
    parameter int            AW       = PIPE_AW,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                clk1,
    input  logic                rst_n,
    if_prefetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] pc;
    logic [AW-1:0] pend_addr;
    logic          pending;
    logic          stop;

    logic [CW-1:0] q_count;
    logic          q_full;
    logic [CW:0]   credit;
    logic          req;
    logic          push;
    logic          pop;
    logic          head_live;
    iq_entry_t     push_entry;
    iq_entry_t     head;

    // Entries held plus the one response still in flight must fit the queue.
    assign credit = {1'b0, q_count} + {{CW{1'b0}}, pending};
    assign req    = rst_n & ~stop & ~bus.redirect & ~q_full
                  & (credit < (CW+1)'(DEPTH));

    assign push           = pending & ~bus.redirect & ~stop;
    assign push_entry.ir  = bus.imem_rdata;
    assign push_entry.npc = 32'(pend_addr) + 32'd1;

    assign head_live = (q_count != '0) & ~bus.redirect;
    assign pop       = head_live & bus.id_ready;

    iq_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(iq_entry_t))
    ) u_fifo (
        .clk   (clk1),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .din   (push_entry),
        .full  (q_full),
        .count (q_count),
        .dout  (head)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            pend_addr <= RESET_PC;
            pending   <= 1'b0;
            stop      <= 1'b0;
        end else if (bus.redirect) begin
            pc      <= bus.redirect_pc;
            pending <= 1'b0;
            stop    <= 1'b0;
        end else begin
            pending <= req;
            if (req) begin
                pc        <= pc + AW'(1);
                pend_addr <= pc;
            end
            if (push && is_hlt(bus.imem_rdata)) stop <= 1'b1;
        end
    end

    assign bus.imem_req      = req;
    assign bus.imem_addr     = pc;
    assign bus.id_valid      = head_live;
    assign bus.id_ir         = head_live ? head.ir  : 32'd0;
    assign bus.id_npc        = head_live ? head.npc : 32'd0;
    assign bus.fetch_stopped = stop;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: streaming, back-pressure, redirect,
// HLT stop, pc wrap and mid-stream reset against hand-derived cycle values.
module tb_if_prefetch_queue;
    import pipe_pkg::*;

    logic clk1  = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [31:0] mem [1024];

    if_prefetch_queue_if #(.AW(10)) bus ();

    if_prefetch_queue #(
        .DEPTH    (4),
        .AW       (10),
        .RESET_PC (10'd0)
    ) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk1 = ~clk1;

    // One-cycle-latency instruction memory.
    always @(posedge clk1) begin
        if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];
    end

    function automatic logic [31:0] word(input int i);
        return 32'hA000_0000 | 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic next_cyc();
        @(negedge clk1);
        #1;
    endtask

    // Leaves the bench 1 time unit into the first cycle with rst_n high.
    task automatic do_reset();
        @(negedge clk1);
        rst_n = 1'b0;
        @(negedge clk1);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = word(i);
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready    = 1'b1;

        // reset values
        #1;
        chk("rst req",     32'(bus.imem_req),      0);
        chk("rst valid",   32'(bus.id_valid),      0);
        chk("rst ir",      bus.id_ir,              0);
        chk("rst npc",     bus.id_npc,             0);
        chk("rst stopped", 32'(bus.fetch_stopped), 0);

        // streaming with decode always ready
        do_reset();
        chk("s1 req c0",   32'(bus.imem_req),  1);
        chk("s1 addr c0",  32'(bus.imem_addr), 0);
        chk("s1 valid c0", 32'(bus.id_valid),  0);
        next_cyc();
        chk("s1 addr c1",  32'(bus.imem_addr), 1);
        chk("s1 valid c1", 32'(bus.id_valid),  0);
        for (int k = 0; k < 5; k++) begin
            next_cyc();
            chk($sformatf("s1 valid %0d", k), 32'(bus.id_valid),  1);
            chk($sformatf("s1 ir %0d", k),    bus.id_ir,          word(k));
            chk($sformatf("s1 npc %0d", k),   bus.id_npc,         32'(k + 1));
            chk($sformatf("s1 addr %0d", k),  32'(bus.imem_addr), 32'(k + 2));
        end

        // back-pressure: queue fills, requests stop, order preserved
        bus.id_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) next_cyc();
            if (k < 4) begin
                chk($sformatf("s2 req %0d", k),  32'(bus.imem_req),  1);
                chk($sformatf("s2 addr %0d", k), 32'(bus.imem_addr), 32'(k));
            end else begin
                chk($sformatf("s2 noreq %0d", k), 32'(bus.imem_req), 0);
            end
        end
        chk("s2 held ir", bus.id_ir, word(0));
        @(negedge clk1);
        bus.id_ready = 1'b1;
        #1;
        chk("s2 rel ir0",  bus.id_ir,         word(0));
        chk("s2 rel req0", 32'(bus.imem_req), 0);
        for (int j = 1; j < 8; j++) begin
            next_cyc();
            if (j == 1) chk("s2 resume addr", 32'(bus.imem_addr), 4);
            chk($sformatf("s2 valid %0d", j), 32'(bus.id_valid), 1);
            chk($sformatf("s2 ir %0d", j),    bus.id_ir,         word(j));
        end

        // redirect with 3 queued entries and one response in flight
        bus.id_ready = 1'b0;
        do_reset();
        next_cyc();
        next_cyc();
        next_cyc();
        chk("s3 pre valid", 32'(bus.id_valid), 1);
        @(negedge clk1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'd40;
        #1;
        chk("s3 R valid", 32'(bus.id_valid), 0);
        chk("s3 R req",   32'(bus.imem_req), 0);
        @(negedge clk1);
        bus.redirect = 1'b0;
        bus.id_ready = 1'b1;
        #1;
        chk("s3 R1 valid", 32'(bus.id_valid),  0);
        chk("s3 R1 req",   32'(bus.imem_req),  1);
        chk("s3 R1 addr",  32'(bus.imem_addr), 40);
        next_cyc();
        chk("s3 R2 valid", 32'(bus.id_valid),  0);
        chk("s3 R2 addr",  32'(bus.imem_addr), 41);
        next_cyc();
        chk("s3 R3 valid", 32'(bus.id_valid), 1);
        chk("s3 R3 ir",    bus.id_ir,         word(40));
        chk("s3 R3 npc",   bus.id_npc,        41);
        next_cyc();
        chk("s3 R4 ir",    bus.id_ir,         word(41));

        // HLT at address 3 stops fetch; redirect resumes
        mem[3] = {OP_HLT, 26'd3};
        do_reset();
        next_cyc();
        for (int k = 2; k < 5; k++) begin
            next_cyc();
            chk($sformatf("s4 ir c%0d", k), bus.id_ir, word(k - 2));
        end
        chk("s4 c4 addr",    32'(bus.imem_addr),     4);
        chk("s4 c4 stopped", 32'(bus.fetch_stopped), 0);
        next_cyc();
        chk("s4 hlt stopped", 32'(bus.fetch_stopped), 1);
        chk("s4 hlt req",     32'(bus.imem_req),      0);
        chk("s4 hlt ir",      bus.id_ir,              32'h1800_0003);
        chk("s4 hlt npc",     bus.id_npc,             4);
        for (int k = 6; k < 10; k++) begin
            next_cyc();
            chk($sformatf("s4 idle valid %0d", k), 32'(bus.id_valid),      0);
            chk($sformatf("s4 idle req %0d", k),   32'(bus.imem_req),      0);
            chk($sformatf("s4 idle stop %0d", k),  32'(bus.fetch_stopped), 1);
        end
        @(negedge clk1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'd8;
        #1;
        chk("s4 redir req", 32'(bus.imem_req), 0);
        @(negedge clk1);
        bus.redirect = 1'b0;
        #1;
        chk("s4 resume stopped", 32'(bus.fetch_stopped), 0);
        chk("s4 resume addr",    32'(bus.imem_addr),     8);
        next_cyc();
        next_cyc();
        chk("s4 resume ir",  bus.id_ir,  word(8));
        chk("s4 resume npc", bus.id_npc, 9);
        mem[3] = word(3);

        // pc wrap 1023 -> 0
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'd1023;
        do_reset();
        chk("s5 R req", 32'(bus.imem_req), 0);
        @(negedge clk1);
        bus.redirect = 1'b0;
        #1;
        chk("s5 addr 1023", 32'(bus.imem_addr), 1023);
        next_cyc();
        chk("s5 addr wrap", 32'(bus.imem_addr), 0);
        next_cyc();
        chk("s5 ir 1023",  bus.id_ir,  word(1023));
        chk("s5 npc 1024", bus.id_npc, 1024);
        next_cyc();
        chk("s5 ir 0",  bus.id_ir,  word(0));
        chk("s5 npc 1", bus.id_npc, 1);

        // asynchronous reset mid-stream with a response in flight
        do_reset();
        next_cyc();
        next_cyc();
        next_cyc();
        chk("s6 pre ir", bus.id_ir, word(1));
        @(negedge clk1);
        rst_n = 1'b0;
        #1;
        chk("s6 rst req",   32'(bus.imem_req),      0);
        chk("s6 rst valid", 32'(bus.id_valid),      0);
        chk("s6 rst ir",    bus.id_ir,              0);
        chk("s6 rst npc",   bus.id_npc,             0);
        chk("s6 rst stop",  32'(bus.fetch_stopped), 0);
        @(negedge clk1);
        rst_n = 1'b1;
        #1;
        chk("s6 c0 addr",  32'(bus.imem_addr), 0);
        chk("s6 c0 valid", 32'(bus.id_valid),  0);
        next_cyc();
        chk("s6 c1 valid", 32'(bus.id_valid),  0);
        next_cyc();
        chk("s6 c2 ir",  bus.id_ir,  word(0));
        chk("s6 c2 npc", bus.id_npc, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Instruction-fetch front end that feeds the decode stage of the 5-stage pipeline. It streams 32-bit instruction words from a word-addressed instruction memory into a small queue, and presents them to decode with a valid/ready handshake. Each word is paired with its next-PC value. Branch redirects from the execute/memory boundary flush the queue, and fetching stops after an HLT opcode is captured.

## Interface
- DEPTH, 4: queue entries (power of two, ≥2)
- AW, 10: instruction address width (1024-word memory)
- RESET_PC, 0: first fetch address after reset
- clk1  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  read request this cycle
- imem_addr  out  AW  word address of request
- imem_rdata  in  32  read data, valid in cycle after imem_req (fixed 1-cycle latency, no stall)
- redirect  in  1  branch taken; flush and restart
- redirect_pc  in  AW  restart address
- id_valid  out  1  queue head valid toward decode
- id_ir  out  32  instruction at head
- id_npc  out  32  zero-extended address of head instruction + 1
- id_ready  in  1  decode accepts head
- fetch_stopped  out  1  HLT captured, no further requests

## Operation
- State:
  - pc (AW bits)
  - queue storage {ir, npc} × DEPTH, with rd/wr pointers and count (0..DEPTH)
  - pending: request issued last cycle whose response is not yet captured
  - stop flag
- Request rule: imem_req = rst_n & !stop & !redirect & (count + pending < DEPTH).
  - imem_addr = pc.
  - On req, pc ← pc+1, wrapping mod 2^AW (1023+1 → 0); pending ← 1. Otherwise pending ← 0.
- Response capture: if pending and no redirect this cycle, push {imem_rdata, addr+1} at the clock edge.
  - If the pushed opcode imem_rdata[31:26] == HLT (6'b000110), set stop.
  - A response arriving while stop=1 is discarded.
- Pop: when id_valid & id_ready, advance the read pointer.
  - Simultaneous push and pop leaves count unchanged.
- id_valid = (count ≠ 0) & !redirect.
  - id_ir and id_npc read 0 whenever id_valid=0.
- Redirect (highest priority) applies at the edge ending the redirect cycle:
  - count ← 0
  - pending ← 0 (the in-flight response is dropped)
  - stop ← 0
  - pc ← redirect_pc
  - no push and no pop take effect.
- fetch_stopped = stop.

## Timing
- Reset (async assert) values:
  - pc=RESET_PC, count=0, pending=0, stop=0
  - imem_req=0, id_valid=0, id_ir=0, id_npc=0, fetch_stopped=0
- First request is in the first cycle with rst_n high, at address RESET_PC.
- Fetch-to-decode latency: req in cycle N → rdata valid in N+1 → pushed at the edge ending N+1 → id_valid in N+2.
- Sustained throughput is 1 instruction/cycle while id_ready=1.
  - If the queue is full, requests stop, so no response is ever lost.
- Redirect in cycle R:
  - No request is issued in R.
  - The request for redirect_pc is issued in R+1.
  - Its instruction reaches id_valid in R+3.
- HLT pushed at edge E: stop=1 after E; no requests thereafter. The response to a request issued in the cycle before E is discarded.
- Reset asserted mid-operation clears everything immediately, including the in-flight response.

## Structure
- Shared package pipe_pkg:
  - opcode constants (ADD..HLT, LW..BEQZ, 6 bits)
  - instruction-type codes
  - default address width
- One sub-module: iq_fifo, a synchronous FIFO parameterised by DEPTH and width 32+32.
  - Ports: push, pop, flush, full/count, head data.
- Request/credit logic, pc, and HLT detection stay in if_prefetch_queue.

## Test plan
- Reset release, memory words 0..5 distinct, id_ready=1 → imem_addr 0,1,2,… on consecutive cycles; id_ir = mem[0] with id_npc=1 appears 2 cycles after the first request, then one word per cycle.
- id_ready=0 for 10 cycles → count saturates at 4, imem_req drops, no word is lost; on release, words are delivered in order with no gaps or duplicates.
- Redirect to address 40 while the queue holds 3 entries and a request is in flight → id_valid low in the redirect cycle and the next two cycles; next delivered word is mem[40] with id_npc=41; the in-flight word is never delivered.
- HLT at address 3 → delivers addresses 0..3 only; fetch_stopped=1; imem_req stays 0; a later redirect to 8 clears fetch_stopped and resumes from 8.
- pc=1023 → fetches 1023 then 0; id_npc for word 1023 reads 1024 (zero-extended).
- rst_n pulsed low mid-stream with a request in flight → all outputs return to reset values asynchronously; after release, fetch restarts at RESET_PC with no stale words.
